// File: rtl/branch_sentinel_config_pkg.sv
// Shared types and constants for the branch sentinel configuration sequencer.
package branch_sentinel_config_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SLOT,
      BCAST,
      DROP
   } state_t;

   localparam logic SENTINEL_ADDR = 1'b0;
   localparam logic MASK_ADDR     = 1'b1;

endpackage

// File: rtl/thread_slot_counter.sv
// Free-running round-robin thread slot counter mirroring the sentinel's rotation.
module thread_slot_counter #(
   parameter int THREAD_COUNT       = 0,
   parameter int THREAD_COUNT_WIDTH = 0,
   parameter int INITIAL_THREAD     = 0
) (
   input  logic                          clock,
   input  logic                          reset_n,
   output logic [THREAD_COUNT_WIDTH-1:0] slot
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         slot <= INITIAL_THREAD[THREAD_COUNT_WIDTH-1:0];
      end else if (int'(slot) == THREAD_COUNT - 1) begin
         slot <= '0;
      end else begin
         slot <= slot + 1'b1;
      end
   end

endmodule

// File: rtl/branch_sentinel_config_sequencer.sv
// Sequences sentinel/mask writes into the thread slot where the sentinel accepts them.
// Optional broadcast writes are enabled by defining BRANCH_SENTINEL_CONFIG_BROADCAST_EN.
module branch_sentinel_config_sequencer
   import branch_sentinel_config_pkg::*;
#(
   parameter int WORD_WIDTH         = 0,
   parameter int THREAD_COUNT       = 0,
   parameter int THREAD_COUNT_WIDTH = 0,
   parameter int INITIAL_THREAD     = 0
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [THREAD_COUNT_WIDTH-1:0] req_thread,
   input  logic                          req_addr,
   input  logic [WORD_WIDTH-1:0]         req_data,
   input  logic                          req_broadcast,
   output logic                          configuration_wren,
   output logic                          configuration_addr,
   output logic [WORD_WIDTH-1:0]         configuration_data,
   output logic [THREAD_COUNT_WIDTH-1:0] current_thread,
   output logic                          done,
   output logic                          error
);

   state_t                        state, state_next;
   logic                          started;
   logic [THREAD_COUNT_WIDTH-1:0] target, target_next;
   logic [THREAD_COUNT_WIDTH-1:0] next_slot;
   logic                          wren_next, addr_next, done_next, error_next;
   logic [WORD_WIDTH-1:0]         data_next;

   thread_slot_counter #(
      .THREAD_COUNT       (THREAD_COUNT),
      .THREAD_COUNT_WIDTH (THREAD_COUNT_WIDTH),
      .INITIAL_THREAD     (INITIAL_THREAD)
   ) slot_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .slot    (current_thread)
   );

   // wren is registered, so it must be raised one cycle before the target slot arrives
   assign next_slot = (int'(current_thread) == THREAD_COUNT - 1) ? '0 : current_thread + 1'b1;
   assign req_ready = started & (state == IDLE);

`ifdef BRANCH_SENTINEL_CONFIG_BROADCAST_EN
   logic [THREAD_COUNT_WIDTH-1:0] write_count, write_count_next;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         write_count <= '0;
      end else begin
         write_count <= write_count_next;
      end
   end
`else
   logic unused_broadcast;
   assign unused_broadcast = req_broadcast;
`endif

   always_comb begin
      state_next  = state;
      target_next = target;
      wren_next   = 1'b0;
      done_next   = 1'b0;
      error_next  = 1'b0;
      addr_next   = configuration_addr;
      data_next   = configuration_data;
`ifdef BRANCH_SENTINEL_CONFIG_BROADCAST_EN
      write_count_next = write_count;
`endif
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               addr_next   = req_addr;
               data_next   = req_data;
               target_next = req_thread;
`ifdef BRANCH_SENTINEL_CONFIG_BROADCAST_EN
               if (req_broadcast) begin
                  state_next       = BCAST;
                  wren_next        = 1'b1;
                  done_next        = (THREAD_COUNT == 1);
                  write_count_next = '0;
               end else
`endif
               if (int'(req_thread) >= THREAD_COUNT) begin
                  state_next = DROP;
                  done_next  = 1'b1;
                  error_next = 1'b1;
               end else begin
                  state_next = WAIT_SLOT;
                  wren_next  = (next_slot == req_thread);
                  done_next  = (next_slot == req_thread);
               end
            end
         end
         WAIT_SLOT: begin
            if (configuration_wren) begin
               state_next = IDLE;
            end else if (next_slot == target) begin
               wren_next = 1'b1;
               done_next = 1'b1;
            end
         end
`ifdef BRANCH_SENTINEL_CONFIG_BROADCAST_EN
         BCAST: begin
            if (int'(write_count) == THREAD_COUNT - 1) begin
               state_next = IDLE;
            end else begin
               wren_next        = 1'b1;
               write_count_next = write_count + 1'b1;
               done_next        = (int'(write_count) + 1 == THREAD_COUNT - 1);
            end
         end
`endif
         DROP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // started keeps req_ready low until the first edge after reset release
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state              <= IDLE;
         started            <= 1'b0;
         target             <= '0;
         configuration_wren <= 1'b0;
         configuration_addr <= SENTINEL_ADDR;
         configuration_data <= '0;
         done               <= 1'b0;
         error              <= 1'b0;
      end else begin
         state              <= state_next;
         started            <= 1'b1;
         target             <= target_next;
         configuration_wren <= wren_next;
         configuration_addr <= addr_next;
         configuration_data <= data_next;
         done               <= done_next;
         error              <= error_next;
      end
   end

endmodule

// File: tb/tb_branch_sentinel_config_sequencer.sv
// Scoreboard bench for branch_sentinel_config_sequencer (THREAD_COUNT = 8, WORD_WIDTH = 16).
module tb_branch_sentinel_config_sequencer;
   import branch_sentinel_config_pkg::*;

   localparam int TC = 8;
   localparam int WW = 16;
   localparam int TW = 4;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          req_valid;
   logic          req_ready;
   logic [TW-1:0] req_thread;
   logic          req_addr;
   logic [WW-1:0] req_data;
   logic          req_broadcast;
   logic          configuration_wren;
   logic          configuration_addr;
   logic [WW-1:0] configuration_data;
   logic [TW-1:0] current_thread;
   logic          done;
   logic          error;

   typedef struct {
      int            cyc;
      logic          wren;
      logic [TW-1:0] thread;
      logic          addr;
      logic [WW-1:0] data;
      logic          done;
      logic          error;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   bit   busy = 0;
   bit   ready_due = 0;

   always #5 clock = ~clock;

   branch_sentinel_config_sequencer #(
      .WORD_WIDTH         (WW),
      .THREAD_COUNT       (TC),
      .THREAD_COUNT_WIDTH (TW),
      .INITIAL_THREAD     (0)
   ) dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_thread         (req_thread),
      .req_addr           (req_addr),
      .req_data           (req_data),
      .req_broadcast      (req_broadcast),
      .configuration_wren (configuration_wren),
      .configuration_addr (configuration_addr),
      .configuration_data (configuration_data),
      .current_thread     (current_thread),
      .done               (done),
      .error              (error)
   );

   // One clock of progress: advance the cycle model, then check the DUT against the scoreboard.
   task automatic step();
      exp_t e;
      @(posedge clock);
      cyc++;
      @(negedge clock);
      vectors++;
      if (current_thread !== TW'(cyc % TC)) begin
         miscompares++;
         $display("[TB] FAIL current_thread cyc %0d: got %0d expected %0d", cyc, current_thread, cyc % TC);
      end
      if (ready_due) begin
         vectors++;
         if (req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ready_after_done cyc %0d: got %b expected 1", cyc, req_ready);
         end
         ready_due = 0;
      end else if (busy) begin
         vectors++;
         if (req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ready_while_busy cyc %0d: got %b expected 0", cyc, req_ready);
         end
      end
      if (configuration_wren || done || error) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL spurious cyc %0d: got wren=%b done=%b error=%b expected none", cyc, configuration_wren, done, error);
         end else begin
            e = sb.pop_front();
            if (cyc !== e.cyc || configuration_wren !== e.wren || current_thread !== e.thread ||
                done !== e.done || error !== e.error) begin
               miscompares++;
               $display("[TB] FAIL event: got cyc=%0d wren=%b thr=%0d done=%b err=%b expected cyc=%0d wren=%b thr=%0d done=%b err=%b",
                        cyc, configuration_wren, current_thread, done, error, e.cyc, e.wren, e.thread, e.done, e.error);
            end
            if (e.wren) begin
               vectors++;
               if (configuration_addr !== e.addr || configuration_data !== e.data) begin
                  miscompares++;
                  $display("[TB] FAIL write_payload cyc %0d: got addr=%b data=%h expected addr=%b data=%h",
                           cyc, configuration_addr, configuration_data, e.addr, e.data);
               end
            end
            if (e.done) begin
               busy = 0;
               ready_due = 1;
            end
         end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
         vectors++;
         miscompares++;
         e = sb.pop_front();
         $display("[TB] FAIL missing_event cyc %0d: got no wren/done expected event for cyc %0d", cyc, e.cyc);
         if (e.done) busy = 0;
      end
   endtask

   // Present a request, wait (bounded) for acceptance and push the predicted retirement events.
   task automatic applyStimulus(input logic [TW-1:0] thread, input logic addr, input logic [WW-1:0] data,
                                input logic bcast, input bit keep);
      exp_t e;
      bit   got = 0;
      bit   bcast_mode = 0;
      int   a, lat;
`ifdef BRANCH_SENTINEL_CONFIG_BROADCAST_EN
      bcast_mode = bcast;
`endif
      req_thread    = thread;
      req_addr      = addr;
      req_data      = data;
      req_broadcast = bcast;
      req_valid     = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         if (req_ready === 1'b1) begin
            got = 1;
            a = cyc;
            busy = 1;
            if (bcast_mode) begin
               for (int k = 0; k < TC; k++) begin
                  e = '{a + 1 + k, 1'b1, TW'((a + 1 + k) % TC), addr, data, (k == TC - 1), 1'b0};
                  sb.push_back(e);
               end
            end else if (int'(thread) >= TC) begin
               e = '{a + 1, 1'b0, TW'((a + 1) % TC), addr, data, 1'b1, 1'b1};
               sb.push_back(e);
            end else begin
               lat = ((int'(thread) - (a % TC) - 1 + 2 * TC) % TC) + 1;
               e = '{a + lat, 1'b1, thread, addr, data, 1'b1, 1'b0};
               sb.push_back(e);
            end
         end
         step();
      end
      if (!keep) req_valid = 1'b0;
      if (!got) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL accept_timeout: got req_ready=%b expected 1 within 40 cycles", req_ready);
      end
   endtask

   task automatic checkOutput();
      for (int i = 0; i < 40 && sb.size() > 0; i++) step();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
         busy = 0;
      end
      step();
      step();
   endtask

   task automatic wait_for_thread(input int k);
      for (int i = 0; i < TC && (cyc % TC) != k; i++) step();
   endtask

   task automatic test_reset();
      reset_n       = 1'b0;
      req_valid     = 1'b0;
      req_thread    = '0;
      req_addr      = 1'b0;
      req_data      = '0;
      req_broadcast = 1'b0;
      #12;
      vectors += 7;
      if (configuration_wren !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wren: got %b expected 0", configuration_wren); end
      if (configuration_addr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_addr: got %b expected 0", configuration_addr); end
      if (configuration_data !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_data: got %h expected 0000", configuration_data); end
      if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      if (error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_error: got %b expected 0", error); end
      if (req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 0", req_ready); end
      if (current_thread !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_thread: got %0d expected 0", current_thread); end
      @(negedge clock);
      reset_n = 1'b1;
      cyc = 0;
      ready_due = 1;
      step();
   endtask

   task automatic test_single_write();
      wait_for_thread(2);
      applyStimulus(4'd5, SENTINEL_ADDR, 16'hDEAD, 1'b0, 1'b0);
      checkOutput();
      vectors++;
      if (configuration_addr !== SENTINEL_ADDR || configuration_data !== 16'hDEAD) begin
         miscompares++;
         $display("[TB] FAIL hold_payload: got addr=%b data=%h expected addr=0 data=dead", configuration_addr, configuration_data);
      end
   endtask

   task automatic test_full_latency();
      wait_for_thread(3);
      applyStimulus(4'd3, MASK_ADDR, 16'h1234, 1'b0, 1'b0);
      checkOutput();
      wait_for_thread(7);
      applyStimulus(4'd0, SENTINEL_ADDR, 16'h5A5A, 1'b0, 1'b0);
      checkOutput();
   endtask

   task automatic test_back_to_back();
      applyStimulus(4'd6, MASK_ADDR, 16'hA5A5, 1'b0, 1'b1);
      applyStimulus(4'd1, SENTINEL_ADDR, 16'hBEEF, 1'b0, 1'b0);
      checkOutput();
   endtask

   task automatic test_broadcast();
      applyStimulus(4'd2, MASK_ADDR, 16'h00FF, 1'b1, 1'b0);
      checkOutput();
   endtask

   task automatic test_drop();
      applyStimulus(4'd9, SENTINEL_ADDR, 16'hCAFE, 1'b0, 1'b0);
      checkOutput();
   endtask

   task automatic test_reset_abort();
      wait_for_thread(4);
      applyStimulus(4'd4, MASK_ADDR, 16'h7777, 1'b0, 1'b0);
      step();
      step();
      reset_n = 1'b0;
      #1;
      vectors += 3;
      if (configuration_wren !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_wren: got %b expected 0", configuration_wren); end
      if (current_thread !== 4'd0) begin miscompares++; $display("[TB] FAIL abort_thread: got %0d expected 0", current_thread); end
      if (req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_ready: got %b expected 0", req_ready); end
      sb.delete();
      busy = 0;
      ready_due = 0;
      @(negedge clock);
      reset_n = 1'b1;
      cyc = 0;
      ready_due = 1;
      for (int i = 0; i < 2 * TC; i++) step();
   endtask

   initial begin
      $display("[TB] starting");
      test_reset();
      test_single_write();
      test_full_latency();
      test_back_to_back();
      test_broadcast();
      test_drop();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
